// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with a one-entry holding
// register and valid/ready hand-off.
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing. With the
// macro undefined the receiver is 8N1 and parity_err_o is tied low.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line idle, waiting for a synchronized falling edge
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits LSB first, one per bit period
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | timing to mid stop bit, then deliver / flag the frame
// BREAK  | stop bit was low, waiting for the line to return high
module uart_rx #(
    parameter int CLOCKS_PER_BAUD = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int            CW        = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd5
`endif
    } state_e;

    state_e        state_q;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          rx_s;
    logic          cnt_zero;
    logic          parity_bad;

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic perr_q;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    assign parity_bad   = ^{shift_q, par_q};
    assign parity_err_o = perr_q;
`else
    assign parity_bad   = 1'b0;
    assign parity_err_o = 1'b0;
`endif

    assign rx_s        = sync_q[1];
    assign cnt_zero    = (cnt_q == '0);
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection;
    // all flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= sync_q[1];
        end
    end

    // Receive FSM with bit timer, shift register, holding register and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q <= 1'b0;
`endif
            // Hand-off; a delivery in the same cycle below overrides this.
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= HALF_LOAD;
                    end
                end

                START: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!rx_s) begin
                        state_q   <= DATA;
                        cnt_q     <= FULL_LOAD;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                DATA: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= PARITY;
`else
                            state_q   <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        par_q   <= rx_s;
                        cnt_q   <= FULL_LOAD;
                        state_q <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else if (!rx_s) begin
                        // Framing error takes precedence over parity so only
                        // one pulse is raised per frame.
                        ferr_q  <= 1'b1;
                        state_q <= BREAK;
                    end else begin
                        // Returning to IDLE at mid stop bit leaves half a bit
                        // to catch an immediately following start edge.
                        state_q <= IDLE;
                        if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                            perr_q <= 1'b1;
`endif
                        end else if (!valid_q || ready_i) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 104, meaning clk cycles per bit (12 MHz / 115200); legal range >= 8.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_o  output  8  received byte, valid while valid_o=1.
REQ-006 SHALL have port valid_o  output  1  byte available in holding register.
REQ-007 SHALL have port ready_i  input  1  consumer accepts byte when valid_o & ready_i.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse: new byte dropped, holding register full.
REQ-010 SHALL have port parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN).

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer reset to 1; all decisions use the synchronized signal.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
REQ-013 IDLE: on synchronized high-to-low transition, SHALL enter START and load baud counter with CLOCKS_PER_BAUD/2 - 1.
REQ-014 START: at counter zero (mid start bit), SHALL go to DATA if line low, else return to IDLE without any output (glitch reject).
REQ-015 DATA: SHALL sample every CLOCKS_PER_BAUD cycles, 8 bits, LSB first, shifting into a shift register; bit index wraps 7 -> exit.
REQ-016 STOP: at mid stop bit, line high -> deliver byte and go IDLE; line low -> pulse frame_err_o, discard byte, go BREAK.
REQ-017 BREAK: SHALL wait for synchronized line high, then go IDLE.
REQ-018 Delivery: holding register empty or ready_i=1 in delivery cycle -> load data_o, valid_o=1 next cycle.
REQ-019 Delivery while valid_o=1 and ready_i=0 -> pulse overrun_o, keep old data_o and valid_o unchanged.
REQ-020 valid_o SHALL clear the cycle after valid_o & ready_i unless simultaneously reloaded (REQ-018).
REQ-021 data_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-022 Latency: valid_o rises 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD + 1 cycles (+-1) after rx falls at start bit (10*CLOCKS_PER_BAUD with parity enabled).
REQ-023 Return to IDLE at mid stop bit SHALL allow back-to-back frames with zero idle time.
REQ-024 Error and overrun pulses SHALL last exactly one cycle and be mutually exclusive per frame.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counters 0, shift register 0, data_o=0, valid_o=0, all error pulses 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL discard the partial byte; after release, reception restarts only on a new falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: SHALL expect even parity bit after bit 7 (PARITY state, sampled mid-bit); mismatch pulses parity_err_o at stop sample, byte discarded, stop still checked.
REQ-028 Macro undefined: no PARITY state, 8N1 framing, parity_err_o constant 0.

Verification (CLOCKS_PER_BAUD=16)
REQ-029 Send 0xA5 8N1, ready_i=1 -> valid_o one cycle, data_o=0xA5, no error pulses, latency per REQ-022.
REQ-030 Drive rx low 4 cycles then high -> no valid_o, no errors, state returns IDLE.
REQ-031 Send 0x3C with stop bit low, then line high -> frame_err_o one pulse, no valid_o; next frame 0x11 received correctly.
REQ-032 ready_i=0, send 0x01 then 0x02 back-to-back -> data_o=0x01 held, overrun_o one pulse; raise ready_i -> valid_o clears next cycle.
REQ-033 Assert rst_n low mid-DATA of 0xFF, release, send 0x55 -> only 0x55 delivered.
REQ-034 UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err_o pulse, no valid_o; with parity 1 -> data_o=0x07.
